// File: rtl/expr_result_if.sv
// Handshake bundle between the expression result bus and the field streamer.
// The master side drives words in and accepts fields; the slave side is the unpacker.
interface expr_result_if #(
    parameter int unsigned OUT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [89:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_field;
    logic [4:0]       out_idx;
    logic             out_last;
    logic             sig_valid;
    logic [15:0]      sig_out;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_field, out_idx, out_last, sig_valid, sig_out
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_field, out_idx, out_last, sig_valid, sig_out
    );
endinterface

// File: rtl/expr_result_unpacker.sv
// Buffers 90-bit result words in a 2-entry FIFO and streams the 18 fields out, extended to OUT_W.
// Optional per-word signature enabled by defining EXPR_UNPACK_SIG_EN.
module expr_result_unpacker #(
    parameter int unsigned OUT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    expr_result_if.slave bus
);
    localparam int unsigned WORD_W   = 90;
    localparam logic [4:0]  LAST_IDX = 5'd17;
    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_STREAM = 1'b1;

    // Raw bits of field idx, right-aligned; groups of three fields (4,5,6 bits) fill 15 bits each.
    function automatic logic [5:0] field_raw(input logic [WORD_W-1:0] word, input logic [4:0] idx);
        int unsigned     grp, pos, offs, fw, lsb;
        logic [WORD_W-1:0] shifted;
        grp     = 32'(idx) / 32'd3;
        pos     = 32'(idx) % 32'd3;
        offs    = (pos == 32'd0) ? 32'd0 : ((pos == 32'd1) ? 32'd4 : 32'd9);
        fw      = 32'd4 + pos;
        lsb     = 32'd90 - (32'd15 * grp) - offs - fw;
        shifted = word >> lsb;
        return shifted[5:0] & 6'((32'd1 << fw) - 32'd1);
    endfunction

    function automatic logic [OUT_W-1:0] extend(input logic [5:0] raw, input logic [4:0] idx);
        int unsigned fw;
        logic [15:0] wide;
        fw   = 32'd4 + (32'(idx) % 32'd3);
        wide = {10'd0, raw};
        if (((32'(idx) % 32'd6) >= 32'd3) && raw[3'(fw - 32'd1)])
            wide = wide | ~16'((32'd1 << fw) - 32'd1);
        return wide[OUT_W-1:0];
    endfunction

    logic [WORD_W-1:0] mem_q [2];
    logic [WORD_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [0:0]        state_q, state_d;
    logic [4:0]        fc_q, fc_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_field_q, out_field_d;
    logic [4:0]        out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;
    logic              push, hs, pop;

    // FIFO bookkeeping, field sequencing and the next presented field.
    always_comb begin
        push        = bus.in_valid && in_ready_q;
        hs          = out_valid_q && bus.out_ready;
        pop         = hs && (fc_q == LAST_IDX);
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        fc_d        = fc_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            ST_IDLE: begin
                if (count_q != 2'd0) begin
                    state_d = ST_STREAM;
                    fc_d    = 5'd0;
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    if (fc_q == LAST_IDX) begin
                        fc_d = 5'd0;
                        // a word pushed in this same cycle keeps the stream going without a bubble
                        if (count_d == 2'd0) state_d = ST_IDLE;
                    end else begin
                        fc_d = 5'(fc_q + 5'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (count_d < 2'd2);
        out_valid_d = (state_d == ST_STREAM);
        out_idx_d   = fc_d;
        out_last_d  = (fc_d == LAST_IDX);
        out_field_d = out_valid_d ? extend(field_raw(mem_d[rd_ptr_d], fc_d), fc_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            state_q     <= ST_IDLE;
            fc_q        <= 5'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_field_q <= '0;
            out_idx_q   <= 5'd0;
            out_last_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            fc_q        <= fc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_field_q <= out_field_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_field = out_field_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

`ifdef EXPR_UNPACK_SIG_EN
    logic [15:0] sig_q, sig_d, sig_out_q, sig_out_d;
    logic        sig_valid_q, sig_valid_d;
    logic [5:0]  raw_cur;

    // Rotate-xor signature over the raw field bits; field 0 restarts it.
    always_comb begin
        raw_cur     = field_raw(mem_q[rd_ptr_q], fc_q);
        sig_d       = sig_q;
        sig_out_d   = sig_out_q;
        sig_valid_d = 1'b0;
        if (hs) begin
            sig_d = ((fc_q == 5'd0) ? 16'h0000 : {sig_q[14:0], sig_q[15]}) ^ {10'd0, raw_cur};
            if (fc_q == LAST_IDX) begin
                sig_out_d   = sig_d;
                sig_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q       <= 16'h0000;
            sig_out_q   <= 16'h0000;
            sig_valid_q <= 1'b0;
        end else begin
            sig_q       <= sig_d;
            sig_out_q   <= sig_out_d;
            sig_valid_q <= sig_valid_d;
        end
    end

    assign bus.sig_out   = sig_out_q;
    assign bus.sig_valid = sig_valid_q;
`else
    assign bus.sig_out   = 16'h0000;
    assign bus.sig_valid = 1'b0;
`endif
endmodule

// File: tb/tb_expr_result_unpacker.sv
// Self-checking bench for expr_result_unpacker: reference unpack model plus directed literal checks.
module tb_expr_result_unpacker;
    localparam int unsigned OUT_W = 8;
`ifdef EXPR_UNPACK_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]       idx;
        logic [OUT_W-1:0] val;
    } fld_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    expr_result_if #(.OUT_W(OUT_W)) bus ();
    expr_result_unpacker #(.OUT_W(OUT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference unpack: walk field widths from the MSB end of the word.
    function automatic int unsigned m_raw(input logic [89:0] w, input int i);
        int hi = 89;
        int wd;
        int unsigned v = 0;
        for (int k = 0; k < i; k++) hi -= 4 + (k % 3);
        wd = 4 + (i % 3);
        for (int b = 0; b < wd; b++) if (w[hi - wd + 1 + b]) v |= (32'd1 << b);
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] m_ext(input logic [89:0] w, input int i);
        int unsigned raw = m_raw(w, i);
        int wd = 4 + (i % 3);
        int v = int'(raw);
        if ((i % 6) >= 3 && raw >= (32'd1 << (wd - 1))) v -= (1 << wd);
        return OUT_W'(v);
    endfunction

    function automatic int unsigned m_sig(input logic [89:0] w);
        int unsigned s = 0;
        for (int i = 0; i < 18; i++) s = (((s << 1) | (s >> 15)) & 32'hFFFF) ^ m_raw(w, i);
        return s;
    endfunction

    fld_t             fq[$];
    int unsigned      sq[$];
    bit               exp_valid, pulse_due, skip_ready, prev_stall;
    logic [15:0]      sig_hold;
    logic [OUT_W-1:0] prev_field;
    logic [4:0]       prev_idx;
    int               words;
    logic [OUT_W-1:0] cap_field [18];
    logic [15:0]      cap_sig;

    // Compare process: checks outputs each cycle, then advances the model for the coming edge.
    always @(negedge clk) begin : monitor
        bit   push, hs, hs_last;
        int   words_after;
        fld_t f;
        if (!rst_n) begin
            chk("reset_outputs", 128'({bus.out_valid, bus.out_field, bus.out_idx, bus.out_last,
                                       bus.sig_valid, bus.sig_out, bus.in_ready}), 128'(0));
            fq.delete();
            sq.delete();
            exp_valid  = 1'b0;
            pulse_due  = 1'b0;
            skip_ready = 1'b1;
            prev_stall = 1'b0;
            sig_hold   = 16'h0000;
            words      = 0;
        end else begin
            chk("out_valid", 128'(bus.out_valid), 128'(exp_valid));
            if (!skip_ready) chk("in_ready", 128'(bus.in_ready), 128'(words < 2));
            skip_ready = 1'b0;
            chk("sig_valid", 128'(bus.sig_valid), 128'(pulse_due));
            chk("sig_out", 128'(bus.sig_out), 128'(sig_hold));
            if (exp_valid && fq.size() > 0) begin
                chk("out_idx", 128'(bus.out_idx), 128'(fq[0].idx));
                chk("out_field", 128'(bus.out_field), 128'(fq[0].val));
                chk("out_last", 128'(bus.out_last), 128'(fq[0].idx == 5'd17));
            end
            if (prev_stall) begin
                chk("stall_field_stable", 128'(bus.out_field), 128'(prev_field));
                chk("stall_idx_stable", 128'(bus.out_idx), 128'(prev_idx));
            end
            push        = bus.in_valid && bus.in_ready;
            hs          = exp_valid && bus.out_ready && (fq.size() > 0);
            hs_last     = hs && (fq[0].idx == 5'd17);
            words_after = words + 32'(push) - 32'(hs_last);
            exp_valid   = exp_valid ? (words_after > 0) : (words > 0);
            pulse_due   = 1'b0;
            if (hs) begin
                cap_field[fq[0].idx] = bus.out_field;
                f = fq.pop_front();
            end
            if (hs_last) begin
                pulse_due = SIG_EN;
                if (SIG_EN) sig_hold = 16'(sq[0]);
                void'(sq.pop_front());
            end
            if (push) begin
                for (int i = 0; i < 18; i++) fq.push_back('{idx: 5'(i), val: m_ext(bus.in_data, i)});
                sq.push_back(m_sig(bus.in_data));
            end
            words = words_after;
            if (bus.sig_valid) cap_sig = bus.sig_out;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_field = bus.out_field;
            prev_idx   = bus.out_idx;
        end
    end

    logic [89:0] wl [4];

    task automatic stream_words(input int n, input bit rand_rdy);
        int sent = 0;
        int guard = 0;
        bit acc;
        bus.in_valid  = (n > 0);
        bus.in_data   = wl[0];
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        while ((sent < n || fq.size() > 0) && guard < 3000) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            bus.in_valid  = (sent < n);
            bus.in_data   = (sent < n) ? wl[sent] : '0;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            guard++;
        end
        if (guard >= 3000) chk("stream_timeout", 128'(guard), 128'(0));
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        for (int i = 0; i < 18; i++) cap_field[i] = '0;
        cap_sig = 16'hDEAD;
    endtask

    initial begin
        int first_v, first_l, first_s, k;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-zero word: latency, field count and signature pulse timing.
        bus.in_valid = 1'b1; bus.in_data = '0; bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        first_v = 0; first_l = 0; first_s = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (bus.out_valid && first_v == 0) first_v = c;
            if (bus.out_valid && bus.out_last && first_l == 0) first_l = c;
            if (bus.sig_valid && first_s == 0) first_s = c;
        end
        chk("zero_first_valid_cycle", 128'(first_v), 128'(2));
        chk("zero_last_cycle", 128'(first_l), 128'(19));
`ifdef EXPR_UNPACK_SIG_EN
        chk("zero_sig_cycle", 128'(first_s), 128'(20));
        chk("zero_sig_value", 128'(cap_sig), 128'(16'h0000));
`else
        chk("zero_no_sig_pulse", 128'(first_s), 128'(0));
`endif
        @(posedge clk); #1;

        // Single-field words with hand-computed extensions.
        clear_caps(); wl[0] = 90'hF << 86; stream_words(1, 1'b0);
        chk("y0_field", 128'(cap_field[0]), 128'(8'h0F));
`ifdef EXPR_UNPACK_SIG_EN
        chk("y0_sig", 128'(cap_sig), 128'(16'h001E));
`endif
        clear_caps(); wl[0] = 90'h8 << 71; stream_words(1, 1'b0);
        chk("y3_neg_field", 128'(cap_field[3]), 128'(8'hF8));
        clear_caps(); wl[0] = 90'h3F; stream_words(1, 1'b0);
        chk("y17_field", 128'(cap_field[17]), 128'(8'hFF));
`ifdef EXPR_UNPACK_SIG_EN
        chk("y17_sig", 128'(cap_sig), 128'(16'h003F));
`endif
        clear_caps(); wl[0] = (90'h20 << 60) | (90'h3F << 75); stream_words(1, 1'b0);
        chk("y5_neg_field", 128'(cap_field[5]), 128'(8'hE0));
        chk("y2_unsigned_field", 128'(cap_field[2]), 128'(8'h3F));

        // Three back-to-back words against a stalled consumer.
        for (int i = 0; i < 3; i++) wl[i] = 90'({$urandom, $urandom, $urandom});
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = wl[0];
        @(negedge clk); chk("b2b_ready_first", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1 bus.in_data = wl[1];
        @(negedge clk); chk("b2b_ready_second", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1 bus.in_data = wl[2];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("b2b_full_hold", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin k = c; break; end
        end
        chk("b2b_third_accept_cycle", 128'(k), 128'(19));
        @(posedge clk); #1 bus.in_valid = 1'b0;
        for (int g = 0; g < 200 && fq.size() > 0; g++) begin @(posedge clk); #1; end
        chk("b2b_drained", 128'(fq.size()), 128'(0));
        repeat (3) @(posedge clk);
        #1;

        // Random backpressure over several random words.
        for (int i = 0; i < 4; i++) wl[i] = 90'({$urandom, $urandom, $urandom});
        stream_words(4, 1'b1);

        // Reset in the middle of a word.
        wl[0] = 90'({$urandom, $urandom, $urandom});
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = wl[0];
        @(posedge clk); #1 bus.in_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 5'd9) begin k = 1; break; end
        end
        chk("reset_reached_idx9", 128'(k), 128'(1));
        #2 rst_n = 1'b0;
        #1 chk("reset_immediate_zero", 128'({bus.out_valid, bus.out_field, bus.out_idx, bus.out_last,
                                             bus.sig_valid, bus.sig_out}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("ready_after_reset", 128'(bus.in_ready), 128'(1));
        @(posedge clk); #1;
        clear_caps(); wl[0] = 90'h5 << 86; stream_words(1, 1'b0);
        chk("post_reset_y0", 128'(cap_field[0]), 128'(8'h05));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
